// File: rtl/chan_cksum_regs.sv
// chan_cksum_regs: channel-side register bank for the FX2 comm_fpga interface.
// Plain byte registers, a checksum fed by channel-0 writes, a control/status
// channel, a snapshotted multi-byte checksum readback and a byte FIFO channel.
// Optional feature macro: CHAN_CKSUM_FLETCHER_EN selects a Fletcher-16 checksum
// (width fixed at 16) instead of the plain modular byte sum.
module chan_cksum_regs #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned FIFO_DEPTH = 16,
`ifdef CHAN_CKSUM_FLETCHER_EN
  localparam int unsigned CKSUM_W   = 16
`else
  parameter int unsigned CKSUM_W    = 16
`endif
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [6:0]         chanAddr_in,
  input  logic [7:0]         chanDataWr_in,
  input  logic               chanWrite_in,
  output logic               chanGotRoom_out,
  output logic [7:0]         chanDataRd_out,
  input  logic               chanRead_in,
  output logic               chanGotData_out,
  output logic [CKSUM_W-1:0] cksum_out,
  output logic [7:0]         reg0_out,
  output logic [4:0]         fifoCount_out
);

  localparam int unsigned NB   = CKSUM_W / 8;
  localparam int unsigned PW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = 5;
  localparam logic [6:0] CTRL_A  = 7'(NUM_REGS);
  localparam logic [6:0] CKSUM_A = 7'(NUM_REGS + 1);
  localparam logic [6:0] FIFO_A  = 7'(NUM_REGS + 2);

  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];
  logic [7:0]         mem_q  [FIFO_DEPTH];
  logic [CKSUM_W-1:0] cksum_q, cksum_d, shadow_q, shadow_d, cksum_acc_c;
  logic [PW-1:0]      p_q, p_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]    count_q, count_d;

  logic is_reg_c, is_ctrl_c, is_cksum_c, is_fifo_c;
  logic full_c, empty_c, push_c;
  logic [7:0] rd_data_c;

  assign is_reg_c   = (chanAddr_in < CTRL_A);
  assign is_ctrl_c  = (chanAddr_in == CTRL_A);
  assign is_cksum_c = (chanAddr_in == CKSUM_A);
  assign is_fifo_c  = (chanAddr_in == FIFO_A);
  assign full_c     = (count_q == CNTW'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign push_c     = chanWrite_in & is_fifo_c & ~full_c & ~reset_in;

  assign chanGotRoom_out = ~(is_fifo_c & full_c);
  assign chanGotData_out = ~(is_fifo_c & empty_c);
  assign chanDataRd_out  = rd_data_c;
  assign cksum_out       = cksum_q;
  assign reg0_out        = regs_q[0];
  assign fifoCount_out   = count_q;

  // Checksum value after accumulating the current write byte
`ifdef CHAN_CKSUM_FLETCHER_EN
  logic [8:0] lo_sum_c, hi_sum_c;
  logic [7:0] lo_new_c, hi_new_c;
  always_comb begin
    lo_sum_c    = 9'(cksum_q[7:0]) + 9'(chanDataWr_in);
    lo_new_c    = (lo_sum_c >= 9'd255) ? 8'(lo_sum_c - 9'd255) : lo_sum_c[7:0];
    hi_sum_c    = 9'(cksum_q[15:8]) + 9'(lo_new_c);
    hi_new_c    = (hi_sum_c >= 9'd255) ? 8'(hi_sum_c - 9'd255) : hi_sum_c[7:0];
    cksum_acc_c = {hi_new_c, lo_new_c};
  end
`else
  always_comb begin
    cksum_acc_c = cksum_q + CKSUM_W'(chanDataWr_in);
  end
`endif

  // Combinational read mux; unmapped channels return zero
  always_comb begin
    rd_data_c = 8'h00;
    if (is_reg_c) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (chanAddr_in == 7'(k)) rd_data_c = regs_q[k];
      end
    end else if (is_ctrl_c) begin
      rd_data_c = {full_c, empty_c, 1'b0, count_q};
    end else if (is_cksum_c) begin
      rd_data_c = (p_q == '0) ? cksum_q[7:0] : 8'(shadow_q >> {p_q, 3'b000});
    end else if (is_fifo_c) begin
      rd_data_c = empty_c ? 8'h00 : mem_q[rd_ptr_q];
    end
  end

  // Next-state: a write takes priority and suppresses any simultaneous read
  always_comb begin
    regs_d   = regs_q;
    cksum_d  = cksum_q;
    shadow_d = shadow_q;
    p_d      = p_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (chanWrite_in) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (chanAddr_in == 7'(k)) regs_d[k] = chanDataWr_in;
      end
      if (chanAddr_in == 7'd0) cksum_d = cksum_acc_c;
      if (is_ctrl_c) begin
        p_d = '0;
        if (chanDataWr_in[0]) cksum_d = '0;
        if (chanDataWr_in[1]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end
      end
      if (is_fifo_c && !full_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CNTW'(1);
      end
    end else if (chanRead_in) begin
      if (is_cksum_c) begin
        if (p_q == '0) shadow_d = cksum_q;
        p_d = (p_q == PW'(NB - 1)) ? '0 : p_q + PW'(1);
      end
      if (is_fifo_c && !empty_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q - CNTW'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= 8'h00;
      cksum_q  <= '0;
      shadow_q <= '0;
      p_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      cksum_q  <= cksum_d;
      shadow_q <= shadow_d;
      p_q      <= p_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge clk_in) begin
    if (push_c) mem_q[wr_ptr_q] <= chanDataWr_in;
  end

endmodule

// File: tb/tb_chan_cksum_regs.sv
// Randomized and directed bench for chan_cksum_regs against a queue-based model.
module tb_chan_cksum_regs;

  localparam int N      = 4;
  localparam int CW     = 16;
  localparam int FD     = 16;
  localparam int NB     = CW / 8;
  localparam int A_CTRL = N;
  localparam int A_CK   = N + 1;
  localparam int A_FIFO = N + 2;
  localparam int A_UNM  = 100;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [6:0]    chanAddr_in;
  logic [7:0]    chanDataWr_in;
  logic          chanWrite_in;
  logic          chanGotRoom_out;
  logic [7:0]    chanDataRd_out;
  logic          chanRead_in;
  logic          chanGotData_out;
  logic [CW-1:0] cksum_out;
  logic [7:0]    reg0_out;
  logic [4:0]    fifoCount_out;

  always #5 clk_in = ~clk_in;

  chan_cksum_regs dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .chanAddr_in     (chanAddr_in),
    .chanDataWr_in   (chanDataWr_in),
    .chanWrite_in    (chanWrite_in),
    .chanGotRoom_out (chanGotRoom_out),
    .chanDataRd_out  (chanDataRd_out),
    .chanRead_in     (chanRead_in),
    .chanGotData_out (chanGotData_out),
    .cksum_out       (cksum_out),
    .reg0_out        (reg0_out),
    .fifoCount_out   (fifoCount_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  byte unsigned m_regs [N];
  longint       m_ck, m_sh;
  int           m_p;
  byte unsigned m_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
    m_ck = 0;
    m_sh = 0;
    m_p  = 0;
    m_q.delete();
  endfunction

  function automatic void model_add(input byte unsigned b);
`ifdef CHAN_CKSUM_FLETCHER_EN
    longint lo, hi;
    lo   = ((m_ck & 255) + b) % 255;
    hi   = (((m_ck >> 8) & 255) + lo) % 255;
    m_ck = hi * 256 + lo;
`else
    m_ck = (m_ck + b) % (longint'(1) << CW);
`endif
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    if (a < N)       return m_regs[a];
    if (a == A_CTRL) return {m_q.size() == FD, m_q.size() == 0, 1'b0, 5'(m_q.size())};
    if (a == A_CK)   return (m_p == 0) ? 8'(m_ck) : 8'(m_sh >> (8 * m_p));
    if (a == A_FIFO) return (m_q.size() > 0) ? m_q[0] : 8'h00;
    return 8'h00;
  endfunction

  function automatic void model_edge(input bit rst, input int a, input bit wr, input bit rd,
                                     input byte unsigned d);
    if (rst) begin
      model_reset();
    end else if (wr) begin
      if (a < N) m_regs[a] = d;
      if (a == 0) model_add(d);
      if (a == A_CTRL) begin
        if (d[0]) m_ck = 0;
        if (d[1]) m_q.delete();
        m_p = 0;
      end
      if (a == A_FIFO && m_q.size() < FD) m_q.push_back(d);
    end else if (rd) begin
      if (a == A_CK) begin
        if (m_p == 0) m_sh = m_ck;
        m_p = (m_p + 1) % NB;
      end
      if (a == A_FIFO && m_q.size() > 0) void'(m_q.pop_front());
    end
  endfunction

  // One cycle: drive at negedge, check everything mid-cycle, update model at posedge
  task automatic step(input bit rst, input int a, input bit wr, input bit rd, input logic [7:0] d,
                      output logic [7:0] rd_o, output logic gd_o, output logic gr_o);
    @(negedge clk_in);
    reset_in      = rst;
    chanAddr_in   = 7'(a);
    chanWrite_in  = wr;
    chanRead_in   = rd;
    chanDataWr_in = d;
    #1;
    rd_o = chanDataRd_out;
    gd_o = chanGotData_out;
    gr_o = chanGotRoom_out;
    check_eq("rd_data", 64'(chanDataRd_out), 64'(exp_rd(a)));
    check_eq("got_data", 64'(chanGotData_out), 64'(!(a == A_FIFO && m_q.size() == 0)));
    check_eq("got_room", 64'(chanGotRoom_out), 64'(!(a == A_FIFO && m_q.size() == FD)));
    check_eq("reg0", 64'(reg0_out), 64'(m_regs[0]));
    check_eq("cksum", 64'(cksum_out), 64'(m_ck));
    check_eq("fifo_count", 64'(fifoCount_out), 64'(m_q.size()));
    @(posedge clk_in);
    model_edge(rst, a, wr, rd, d);
  endtask

  logic [7:0] r;
  logic       gd, gr;

  initial begin
    reset_in      = 1'b1;
    chanAddr_in   = '0;
    chanDataWr_in = '0;
    chanWrite_in  = 1'b0;
    chanRead_in   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    step(1, 0, 0, 0, 8'h00, r, gd, gr);
    check_eq("reset_gd", 64'(gd), 64'd1);
    check_eq("reset_gr", 64'(gr), 64'd1);

    // Three channel-0 writes
    step(0, 0, 1, 0, 8'h12, r, gd, gr);
    step(0, 0, 1, 0, 8'h34, r, gd, gr);
    step(0, 0, 1, 0, 8'hFF, r, gd, gr);
    step(0, 0, 0, 0, 8'h00, r, gd, gr);
    check_eq("tp_reg0", 64'(r), 64'hFF);
`ifndef CHAN_CKSUM_FLETCHER_EN
    step(0, A_CK, 1'b0, 1'b1, 8'h00, r, gd, gr);
    check_eq("tp_ck_p0", 64'(r), 64'h45);
    step(0, 0, 1, 0, 8'h10, r, gd, gr);
    step(0, A_CK, 0, 1, 8'h00, r, gd, gr);
    check_eq("tp_ck_p1", 64'(r), 64'h01);
    step(0, 0, 0, 0, 8'h00, r, gd, gr);
    @(negedge clk_in); #1;
    check_eq("tp_ck_live", 64'(cksum_out), 64'h0155);
`endif

    // Fill FIFO, overflow attempt, drain
    for (int i = 0; i < FD; i++) step(0, A_FIFO, 1, 0, 8'(i), r, gd, gr);
    step(0, A_CTRL, 0, 0, 8'h00, r, gd, gr);
    check_eq("tp_full_ctrl", 64'(r), 64'h90);
    step(0, A_FIFO, 1, 0, 8'hAA, r, gd, gr);
    check_eq("tp_full_room", 64'(gr), 64'd0);
    for (int i = 0; i < FD; i++) begin
      step(0, A_FIFO, 0, 1, 8'h00, r, gd, gr);
      check_eq("tp_pop_order", 64'(r), 64'(i));
    end
    step(0, A_CTRL, 0, 0, 8'h00, r, gd, gr);
    check_eq("tp_empty_ctrl", 64'(r), 64'h40);
    step(0, A_FIFO, 0, 1, 8'h00, r, gd, gr);
    check_eq("tp_empty_gd", 64'(gd), 64'd0);

    // Wrap-around: push 12, pop 8, push 10, pop 14
    for (int i = 0; i < 12; i++) step(0, A_FIFO, 1, 0, 8'($urandom), r, gd, gr);
    for (int i = 0; i < 8; i++)  step(0, A_FIFO, 0, 1, 8'h00, r, gd, gr);
    for (int i = 0; i < 10; i++) step(0, A_FIFO, 1, 0, 8'($urandom), r, gd, gr);
    for (int i = 0; i < 14; i++) step(0, A_FIFO, 0, 1, 8'h00, r, gd, gr);
    step(0, A_UNM, 0, 0, 8'h00, r, gd, gr);
    @(negedge clk_in); #1;
    check_eq("tp_wrap_count", 64'(fifoCount_out), 64'd0);

    // CTRL 0x03 clears checksum, flushes FIFO, resets byte pointer
    for (int i = 0; i < 5; i++) step(0, A_FIFO, 1, 0, 8'(i + 1), r, gd, gr);
    step(0, A_CTRL, 1, 0, 8'h01, r, gd, gr);
    step(0, 0, 1, 0, 8'hAA, r, gd, gr);
    step(0, A_CK, 0, 1, 8'h00, r, gd, gr);
    step(0, A_CTRL, 1, 0, 8'h03, r, gd, gr);
    step(0, A_UNM, 0, 0, 8'h00, r, gd, gr);
    @(negedge clk_in); #1;
    check_eq("tp_clr_count", 64'(fifoCount_out), 64'd0);
    check_eq("tp_clr_cksum", 64'(cksum_out), 64'd0);
    step(0, 0, 1, 0, 8'h5A, r, gd, gr);
    step(0, A_CK, 0, 0, 8'h00, r, gd, gr);
    check_eq("tp_clr_p0", 64'(r), 64'h5A);

    // Reset overriding a simultaneous push and register write
    step(0, 2, 1, 0, 8'h77, r, gd, gr);
    step(0, A_FIFO, 1, 0, 8'h11, r, gd, gr);
    step(1, A_FIFO, 1, 0, 8'h55, r, gd, gr);
    step(1, 2, 1, 0, 8'h99, r, gd, gr);
    step(0, 2, 0, 0, 8'h00, r, gd, gr);
    check_eq("tp_rst_reg2", 64'(r), 64'h00);
    step(0, A_FIFO, 0, 0, 8'h00, r, gd, gr);
    check_eq("tp_rst_gd", 64'(gd), 64'd0);

    // Randomized traffic, biased towards FIFO and checksum channels
    for (int i = 0; i < 800; i++) begin
      int sel, a;
      bit wr, rd, rst;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: a = A_FIFO;
        4, 5:       a = A_CK;
        6:          a = A_CTRL;
        7:          a = A_UNM;
        default:    a = int'($urandom_range(0, N - 1));
      endcase
      wr  = ($urandom_range(0, 99) < 45);
      rd  = ($urandom_range(0, 99) < 55);
      rst = ($urandom_range(0, 199) == 0);
      step(rst, a, wr, rd, 8'($urandom), r, gd, gr);
    end
    step(0, A_UNM, 0, 0, 8'h00, r, gd, gr);
    step(0, A_UNM, 0, 0, 8'h00, r, gd, gr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
